// File: rtl/trace_cmd_dispatcher.sv
// ============================================================================
// trace_cmd_dispatcher
// ----------------------------------------------------------------------------
// Purpose:
//   Feeds the L1 cache command port from a stream of trace records.
//   - Records {code, address} are queued in a small FIFO.
//   - Each popped code is translated into a 3-bit cache command.
//   - The cache write/processing handshake is driven with one command in
//     flight at a time.
//   - Code 9 (print) becomes a one-cycle status pulse.
//   - Unknown codes are dropped, pulsed on bad_code and counted.
//
// Optional feature (compile-time macro):
//   DISPATCH_TIMEOUT_EN - when defined, a wait in ACK/BUSY that lasts TIMEOUT
//   cycles is aborted: timeout_err is set (sticky until rst) and the FSM
//   returns to IDLE. When undefined, the FSM waits indefinitely and
//   timeout_err is tied to 0.
//
// Parameters:
//   ADDR_W   address width, matches the cache address port
//   DEPTH    FIFO entries, power of two, >= 2
//   TIMEOUT  abort threshold in cycles (only used with DISPATCH_TIMEOUT_EN)
//
// Ports:
//   clk               in   clock, all state updates on posedge
//   rst               in   synchronous active-high reset
//   in_valid          in   trace record valid
//   in_ready          out  FIFO can accept (= !full)
//   in_code    [3:0]  in   trace code
//   in_addr    [AW]   in   trace address
//   cache_write       out  one-cycle issue strobe to the cache
//   cache_command [2:0] out cache command (0 READ,1 WRITE,2 INVAL,3 CLEAR,4 L2REQ)
//   cache_address [AW] out address, stable from issue until BUSY exits
//   cache_processing  in   cache busy flag
//   print_pulse       out  one-cycle pulse for a popped code 9
//   bad_code          out  one-cycle pulse for a popped unknown code
//   issued_cnt [31:0] out  commands handed to the cache (wraps)
//   bad_cnt    [15:0] out  unknown codes dropped (saturates at 16'hFFFF)
//   idle              out  FIFO empty and FSM in IDLE
//   timeout_err       out  sticky abort flag
//   state_dbg  [1:0]  out  current FSM state (0 IDLE, 1 ACK, 2 BUSY)
//
// Handshake semantics (input side):
//   A record is transferred on a rising clk edge where in_valid && in_ready.
//   in_ready depends only on registered FIFO occupancy: it is low whenever
//   the FIFO is full, even if an entry is popped in that same cycle. The
//   producer may change in_code/in_addr freely while in_valid is low.
// Handshake semantics (cache side):
//   cache_write is high for exactly one cycle per command; the dispatcher
//   then waits for cache_processing to rise and fall again before a new
//   command may be popped, and never pops while cache_processing is high.
// ============================================================================
module trace_cmd_dispatcher #(
    parameter int ADDR_W  = 60,
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_code,
    input  logic [ADDR_W-1:0] in_addr,
    output logic              cache_write,
    output logic [2:0]        cache_command,
    output logic [ADDR_W-1:0] cache_address,
    input  logic              cache_processing,
    output logic              print_pulse,
    output logic              bad_code,
    output logic [31:0]       issued_cnt,
    output logic [15:0]       bad_cnt,
    output logic              idle,
    output logic              timeout_err,
    output logic [1:0]        state_dbg
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int REC_W = ADDR_W + 4;

    // Cache command encodings.
    localparam logic [2:0] CMD_READ  = 3'd0;
    localparam logic [2:0] CMD_WRITE = 3'd1;
    localparam logic [2:0] CMD_INVAL = 3'd2;
    localparam logic [2:0] CMD_CLEAR = 3'd3;
    localparam logic [2:0] CMD_L2REQ = 3'd4;

    localparam logic [3:0] CODE_PRINT = 4'd9;

    // Elaboration-time parameter sanity checks.
    if ((DEPTH < 2) || (DEPTH != (1 << PTR_W))) begin : g_bad_depth
        $error("trace_cmd_dispatcher: DEPTH must be a power of two >= 2");
    end
    if ((TIMEOUT < 1) || (TIMEOUT > 65535)) begin : g_bad_timeout
        $error("trace_cmd_dispatcher: TIMEOUT must be in 1..65535");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK  = 2'd1,
        BUSY = 2'd2
    } state_t;

    state_t state;

    // ------------------------------------------------------------------
    // Record FIFO
    // ------------------------------------------------------------------
    logic [REC_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign in_ready = !full;
    assign push     = in_valid && in_ready;

    // A pop only happens from IDLE with the cache quiet; at most one per cycle.
    assign pop = (state == IDLE) && !empty && !cache_processing;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_code, in_addr};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Head decode
    // ------------------------------------------------------------------
    logic [REC_W-1:0]  head;
    logic [3:0]        head_code;
    logic [ADDR_W-1:0] head_addr;
    logic [3:0]        head_map;
    logic              head_fwd;
    logic [2:0]        head_cmd;

    // Returns {forwardable, command}; print and unknown codes are not forwardable.
    function automatic logic [3:0] map_code(input logic [3:0] code);
        case (code)
            4'd0:    return {1'b1, CMD_READ};
            4'd1:    return {1'b1, CMD_WRITE};
            4'd2:    return {1'b1, CMD_READ};   // ifetch reads like a data read
            4'd3:    return {1'b1, CMD_INVAL};
            4'd4:    return {1'b1, CMD_L2REQ};
            4'd8:    return {1'b1, CMD_CLEAR};
            default: return 4'b0000;
        endcase
    endfunction

    assign head      = mem[rd_ptr];
    assign head_code = head[REC_W-1:ADDR_W];
    assign head_addr = head[ADDR_W-1:0];
    assign head_map  = map_code(head_code);
    assign head_fwd  = head_map[3];
    assign head_cmd  = head_map[2:0];

    // ------------------------------------------------------------------
    // Optional wait timeout
    // ------------------------------------------------------------------
    logic timeout_hit;

`ifdef DISPATCH_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);

    logic [15:0] to_cnt;

    // Fires on the edge where the wait counter would reach TIMEOUT.
    assign timeout_hit = ((state == ACK) || (state == BUSY)) &&
                         (16'(to_cnt + 16'd1) == TIMEOUT_C);

    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (pop && head_fwd) begin
                to_cnt <= '0;
            end else if (state != IDLE) begin
                to_cnt <= to_cnt + 16'd1;
            end
            if (timeout_hit) begin
                timeout_err <= 1'b1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Dispatch FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cache_write   <= 1'b0;
            cache_command <= '0;
            cache_address <= '0;
            print_pulse   <= 1'b0;
            bad_code      <= 1'b0;
            issued_cnt    <= '0;
            bad_cnt       <= '0;
        end else begin
            print_pulse <= 1'b0;
            bad_code    <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        if (head_fwd) begin
                            cache_command <= head_cmd;
                            cache_address <= head_addr;
                            cache_write   <= 1'b1;
                            issued_cnt    <= issued_cnt + 32'd1;
                            state         <= ACK;
                        end else if (head_code == CODE_PRINT) begin
                            print_pulse <= 1'b1;
                        end else begin
                            bad_code <= 1'b1;
                            if (bad_cnt != 16'hFFFF) begin
                                bad_cnt <= bad_cnt + 16'd1;
                            end
                        end
                    end
                end
                ACK: begin
                    // The strobe is dropped on the first ACK edge regardless
                    // of the cache response, so it is exactly one cycle wide.
                    cache_write <= 1'b0;
                    if (timeout_hit) begin
                        state <= IDLE;
                    end else if (cache_processing) begin
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    cache_write <= 1'b0;
                    if (timeout_hit) begin
                        state <= IDLE;
                    end else if (!cache_processing) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    cache_write <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

    assign idle      = empty && (state == IDLE);
    assign state_dbg = state;

endmodule

// File: tb/tb_trace_cmd_dispatcher.sv
// ============================================================================
// tb_trace_cmd_dispatcher
// ----------------------------------------------------------------------------
// Randomized bench for trace_cmd_dispatcher. A reference model keeps an
// ordered queue of the commands each pushed record should produce plus
// print/bad/issue tallies; a monitor compares every cache strobe against it.
// A simple cache model answers strobes with a random delay and busy length.
// ============================================================================
module tb_trace_cmd_dispatcher;

  localparam int ADDR_W  = 60;
  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 16;
  localparam int W       = ADDR_W + 3;

  // --------------------------------------------------------------------------
  // Clock / reset / DUT
  // --------------------------------------------------------------------------
  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_code;
  logic [ADDR_W-1:0] in_addr;
  logic              cache_write;
  logic [2:0]        cache_command;
  logic [ADDR_W-1:0] cache_address;
  logic              cache_processing;
  logic              print_pulse;
  logic              bad_code;
  logic [31:0]       issued_cnt;
  logic [15:0]       bad_cnt;
  logic              idle;
  logic              timeout_err;
  logic [1:0]        state_dbg;

  always #5 clk = ~clk;

  trace_cmd_dispatcher #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_code         (in_code),
    .in_addr         (in_addr),
    .cache_write     (cache_write),
    .cache_command   (cache_command),
    .cache_address   (cache_address),
    .cache_processing(cache_processing),
    .print_pulse     (print_pulse),
    .bad_code        (bad_code),
    .issued_cnt      (issued_cnt),
    .bad_cnt         (bad_cnt),
    .idle            (idle),
    .timeout_err     (timeout_err),
    .state_dbg       (state_dbg)
  );

  // --------------------------------------------------------------------------
  // Checking
  // --------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model
  // --------------------------------------------------------------------------
  logic [W-1:0] exp_q[$];
  int exp_issued = 0;
  int exp_bad    = 0;
  int exp_print  = 0;
  int obs_print  = 0;
  int obs_bad    = 0;

  task automatic model_push(input logic [3:0] c, input logic [ADDR_W-1:0] a);
    case (c)
      4'd0, 4'd2: begin exp_q.push_back({3'd0, a}); exp_issued++; end
      4'd1:       begin exp_q.push_back({3'd1, a}); exp_issued++; end
      4'd3:       begin exp_q.push_back({3'd2, a}); exp_issued++; end
      4'd4:       begin exp_q.push_back({3'd4, a}); exp_issued++; end
      4'd8:       begin exp_q.push_back({3'd3, a}); exp_issued++; end
      4'd9:       exp_print++;
      default:    if (exp_bad < 65535) exp_bad++;
    endcase
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_issued = 0;
    exp_bad    = 0;
    exp_print  = 0;
    obs_print  = 0;
    obs_bad    = 0;
  endtask

  // --------------------------------------------------------------------------
  // Cache model: drives cache_processing on negedges
  // --------------------------------------------------------------------------
  bit force_busy = 1'b0;
  bit no_respond = 1'b0;
  int busy_lo    = 1;
  int busy_hi    = 3;

  initial begin
    int d;
    int l;
    cache_processing = 1'b0;
    forever begin
      @(negedge clk);
      if (force_busy) begin
        cache_processing = 1'b1;
      end else if (cache_write && !no_respond && !rst) begin
        d = $urandom_range(0, 2);
        l = $urandom_range(busy_lo, busy_hi);
        repeat (d) @(negedge clk);
        cache_processing = 1'b1;
        repeat (l) @(negedge clk);
        cache_processing = 1'b0;
      end else begin
        cache_processing = 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Monitor / scoreboard (samples 1 time unit after each posedge)
  // --------------------------------------------------------------------------
  logic [2:0]        last_cmd;
  logic [ADDR_W-1:0] last_addr;
  logic [W-1:0]      exp_e;
  bit                prev_write;
  bit                seen_issue;
  int                since;
  int                busy_acc;

  always @(posedge clk) begin
    #1;
    if (rst) begin
      last_cmd   = '0;
      last_addr  = '0;
      prev_write = 1'b0;
      seen_issue = 1'b0;
      since      = 0;
      busy_acc   = 0;
    end else begin
      if (print_pulse) obs_print++;
      if (bad_code)    obs_bad++;
      if (cache_write) begin
        check("strobe_width", prev_write, 1'b0);
        check("strobe_while_busy", cache_processing, 1'b0);
        if (seen_issue) check("issue_gap", (since + 1 >= busy_acc + 2), 1'b1);
        check("issue_expected", (exp_q.size() != 0), 1'b1);
        if (exp_q.size() != 0) begin
          exp_e = exp_q.pop_front();
          check("command", cache_command, exp_e[W-1:ADDR_W]);
          check("address", cache_address, exp_e[ADDR_W-1:0]);
        end
        last_cmd   = cache_command;
        last_addr  = cache_address;
        since      = 0;
        busy_acc   = 0;
        seen_issue = 1'b1;
      end else begin
        check("cmd_addr_stable", {cache_command, cache_address}, {last_cmd, last_addr});
        since++;
        busy_acc += int'(cache_processing);
      end
      prev_write = cache_write;
    end
  end

  // --------------------------------------------------------------------------
  // Driver tasks (test thread samples 2 time units after posedge)
  // --------------------------------------------------------------------------
  task automatic push_rec(input logic [3:0] c, input logic [ADDR_W-1:0] a);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("push_accept", in_ready, 1'b1);
    if (in_ready) begin
      in_code  = c;
      in_addr  = a;
      in_valid = 1'b1;
      model_push(c, a);
      @(posedge clk);
      #2;
      in_valid = 1'b0;
    end
  endtask

  task automatic try_push(input logic [3:0] c, input logic [ADDR_W-1:0] a, output bit acc);
    @(negedge clk);
    acc = in_ready;
    if (in_ready) begin
      in_code  = c;
      in_addr  = a;
      in_valid = 1'b1;
      model_push(c, a);
      @(posedge clk);
      #2;
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (!(idle && exp_q.size() == 0 && !cache_processing) && n < 3000) begin
      @(posedge clk);
      #2;
      n++;
    end
    check("drain_in_time", (n < 3000), 1'b1);
    repeat (2) @(posedge clk);
    #2;
    check("issued_cnt", issued_cnt, 64'(exp_issued));
    check("bad_cnt", bad_cnt, 64'(exp_bad));
    check("print_pulses", 64'(obs_print), 64'(exp_print));
    check("bad_pulses", 64'(obs_bad), 64'(exp_bad));
    check("idle_after_drain", idle, 1'b1);
  endtask

  function automatic logic [ADDR_W-1:0] rand_addr();
    return ADDR_W'({$urandom, $urandom});
  endfunction

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  logic [3:0] code_tbl [7] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd8, 4'd9};
  logic [3:0] t2_codes [5] = '{4'd2, 4'd1, 4'd3, 4'd4, 4'd8};

  initial begin
    int n;
    int strobes;
    bit acc;
    logic [3:0] c;

    in_valid = 1'b0;
    in_code  = '0;
    in_addr  = '0;
    rst      = 1'b1;
    repeat (3) @(posedge clk);
    #2;

    // Reset state
    check("rst_cache_write", cache_write, 1'b0);
    check("rst_cache_command", cache_command, 3'd0);
    check("rst_cache_address", cache_address, '0);
    check("rst_print_pulse", print_pulse, 1'b0);
    check("rst_bad_code", bad_code, 1'b0);
    check("rst_issued_cnt", issued_cnt, '0);
    check("rst_bad_cnt", bad_cnt, '0);
    check("rst_timeout_err", timeout_err, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_idle", idle, 1'b1);
    @(negedge clk);
    rst = 1'b0;

    // T1: single read, strobe one cycle after the pop
    push_rec(4'd0, 60'h1234);
    n = 0;
    while (!cache_write && n < 10) begin
      @(posedge clk);
      #2;
      n++;
    end
    check("t1_latency", 64'(n), 64'd1);
    check("t1_command", cache_command, 3'd0);
    check("t1_address", cache_address, 60'h1234);
    wait_drain();

    // T2: every forwardable code in a row
    for (int i = 0; i < 5; i++) push_rec(t2_codes[i], rand_addr());
    wait_drain();

    // T3: print and unknown code produce no issue
    push_rec(4'd9, rand_addr());
    push_rec(4'd7, rand_addr());
    wait_drain();

    // Random traffic
    busy_hi = 4;
    for (int i = 0; i < 43; i++) begin
      if ($urandom_range(0, 3) == 0) c = 4'($urandom_range(0, 15));
      else c = code_tbl[$urandom_range(0, 6)];
      push_rec(c, rand_addr());
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    wait_drain();

    // T4: fill the FIFO while the cache is held busy
    force_busy = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < DEPTH; i++) push_rec(4'($urandom_range(0, 4)), rand_addr());
    @(posedge clk);
    #2;
    check("t4_full_not_ready", in_ready, 1'b0);
    for (int i = 0; i < 2; i++) begin
      try_push(4'd1, rand_addr(), acc);
      check("t4_extra_rejected", acc, 1'b0);
    end
    check("t4_no_issue_while_busy", 64'(exp_q.size()), 64'(DEPTH));
    force_busy = 1'b0;
    wait_drain();

    // T5: reset while BUSY with entries queued
    busy_lo = 20;
    busy_hi = 20;
    push_rec(4'd1, rand_addr());
    n = 0;
    while (!cache_processing && n < 50) begin
      @(posedge clk);
      #2;
      n++;
    end
    for (int i = 0; i < 3; i++) push_rec(4'd1, rand_addr());
    check("t5_in_busy", state_dbg, 2'd2);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #2;
    check("t5_idle", idle, 1'b1);
    check("t5_issued_cnt", issued_cnt, '0);
    check("t5_bad_cnt", bad_cnt, '0);
    check("t5_cache_write", cache_write, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    strobes = 0;
    repeat (30) begin
      @(posedge clk);
      #2;
      if (cache_write) strobes++;
    end
    check("t5_no_strobe", 64'(strobes), 64'd0);
    busy_lo = 1;
    busy_hi = 3;
    wait_drain();

`ifdef DISPATCH_TIMEOUT_EN
    // T6: the cache never answers
    no_respond = 1'b1;
    push_rec(4'd1, rand_addr());
    n = 0;
    while (!cache_write && n < 10) begin
      @(posedge clk);
      #2;
      n++;
    end
    n = 0;
    while (!timeout_err && n < 100) begin
      @(posedge clk);
      #2;
      n++;
    end
    check("t6_timeout_cycle", 64'(n), 64'(TIMEOUT));
    no_respond = 1'b0;
    wait_drain();
    push_rec(4'd3, rand_addr());
    wait_drain();
    check("t6_timeout_sticky", timeout_err, 1'b1);
`else
    check("timeout_err_tied", timeout_err, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
